simd_alu_pipe: RTL and testbench

Parametrised, pipelined successor to the GPU datapath's combinational 4×16-bit SIMD ALU. It operates on LANES independent lanes of LANE_W bits. It adds per-lane shift amounts, arithmetic right shift, min/max/compare, unsigned saturation and a full-width add. It has a fixed two-stage pipeline with valid/ready handshakes on both sides, and sits between operand fetch and register writeback in the GPU execute stage.

---
 rtl/simd_alu_pipe.sv | 97 +++++++++
 tb/tb_simd_alu_pipe.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe: two-stage valid/ready SIMD ALU over LANES lanes of LANE_W bits.
// S1 holds the registered operands, S2 holds the computed result and per-lane zero flags.
module simd_alu_pipe #(
  parameter int LANE_W = 16,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                alu_op,
  input  logic                      sat_en,
  input  logic [LANE_W*LANES-1:0]   a,
  input  logic [LANE_W*LANES-1:0]   b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANE_W*LANES-1:0]   out,
  output logic [LANES-1:0]          lane_zero
);
  localparam int W  = LANE_W * LANES;
  localparam int SW = $clog2(LANE_W);

  logic             s1_valid_q, s2_valid_q, sat_q, s2_adv;
  logic [3:0]       op_q;
  logic [W-1:0]     a_q, b_q, res_q, res_d, wide_sum;
  logic [LANES-1:0] lz_q, lz_d;

  assign s2_adv    = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_adv;
  assign out_valid = s2_valid_q;
  assign out       = res_q;
  assign lane_zero = lz_q;
  assign wide_sum  = a_q + b_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0] la, lb, r, f;
    logic [LANE_W:0]   sum, dif;
    logic [SW-1:0]     sh;
    assign la  = a_q[g*LANE_W +: LANE_W];
    assign lb  = b_q[g*LANE_W +: LANE_W];
    assign sh  = lb[SW-1:0];
    assign sum = {1'b0, la} + {1'b0, lb};
    assign dif = {1'b0, la} - {1'b0, lb};
    always_comb begin
      r = '0;
      case (op_q)
        4'd0:    r = (sat_q && sum[LANE_W]) ? '1 : sum[LANE_W-1:0];
        4'd1:    r = (sat_q && dif[LANE_W]) ? '0 : dif[LANE_W-1:0];
        4'd2:    r = la & lb;
        4'd3:    r = la | lb;
        4'd4:    r = la ^ lb;
        4'd5:    r = la << sh;
        4'd6:    r = la >> sh;
        4'd8:    r = $signed(la) >>> sh;
        4'd9:    r = (la < lb) ? la : lb;
        4'd10:   r = (la < lb) ? lb : la;
        4'd11:   r = {LANE_W{la == lb}};
        4'd12:   r = {LANE_W{la < lb}};
        default: r = '0;
      endcase
    end
    // ADDW bypasses the lane ALUs; its carries ripple across lane boundaries
    assign f = (op_q == 4'd7) ? wide_sum[g*LANE_W +: LANE_W] : r;
    assign res_d[g*LANE_W +: LANE_W] = f;
    assign lz_d[g] = (f == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      op_q       <= '0;
      sat_q      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      res_q      <= '0;
      lz_q       <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (in_valid) begin
          op_q  <= alu_op;
          sat_q <= sat_en;
          a_q   <= a;
          b_q   <= b;
        end
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          res_q <= res_d;
          lz_q  <= lz_d;
        end
      end
    end
  end
endmodule

// File: tb/tb_simd_alu_pipe.sv
// tb_simd_alu_pipe: randomized and directed checks of simd_alu_pipe against a lane-arithmetic model,
// on the default 16x4 configuration and an 8x8 configuration.
module tb_simd_alu_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv0, ir0, sat0, ov0, or0;
  logic [3:0]  op0, lz0;
  logic [63:0] a0, b0, o0;
  logic        iv1, ir1, sat1, ov1, or1;
  logic [3:0]  op1;
  logic [7:0]  lz1;
  logic [63:0] a1, b1, o1;

  int checks = 0;
  int errors = 0;

  simd_alu_pipe #(.LANE_W(16), .LANES(4)) d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .alu_op(op0), .sat_en(sat0),
    .a(a0), .b(b0), .out_valid(ov0), .out_ready(or0), .out(o0), .lane_zero(lz0));

  simd_alu_pipe #(.LANE_W(8), .LANES(8)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .alu_op(op1), .sat_en(sat1),
    .a(a1), .b(b1), .out_valid(ov1), .out_ready(or1), .out(o1), .lane_zero(lz1));

  function automatic logic [63:0] model(input int lw, input int n, input logic [3:0] op,
                                        input logic s, input logic [63:0] a, input logic [63:0] b);
    longint unsigned m, x, y, r, res;
    int sh;
    if (op == 4'd7) return a + b;
    m = (64'd1 << lw) - 1;
    res = 0;
    for (int i = 0; i < n; i++) begin
      x = (a >> (i * lw)) & m;
      y = (b >> (i * lw)) & m;
      sh = int'(y % longint'(lw));
      case (op)
        0:  r = (x + y > m) ? (s ? m : x + y - (m + 1)) : x + y;
        1:  r = (x < y) ? (s ? 0 : x + (m + 1) - y) : x - y;
        2:  r = x & y;
        3:  r = x | y;
        4:  r = x ^ y;
        5:  r = (x << sh) & m;
        6:  r = x >> sh;
        8:  r = ((x >= (m + 1) / 2) ? ((x | ~m) >> sh) : (x >> sh)) & m;
        9:  r = (x < y) ? x : y;
        10: r = (x < y) ? y : x;
        11: r = (x == y) ? m : 0;
        12: r = (x < y) ? m : 0;
        default: r = 0;
      endcase
      res |= r << (i * lw);
    end
    return res;
  endfunction

  function automatic logic [7:0] mlz(input int lw, input int n, input logic [63:0] r);
    logic [7:0] z;
    longint unsigned m;
    z = '0;
    m = (64'd1 << lw) - 1;
    for (int i = 0; i < n; i++) z[i] = ((r >> (i * lw)) & m) == 0;
    return z;
  endfunction

  task automatic beat0(input logic [3:0] op, input logic s, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] r, output logic [3:0] lz, output int lat);
    @(negedge clk);
    iv0 = 1'b1; op0 = op; sat0 = s; a0 = a; b0 = b; or0 = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    iv0 = 1'b0;
    while (!ov0 && lat < 10) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    r = o0; lz = lz0;
  endtask

  task automatic beat1(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       output logic [63:0] r, output logic [7:0] lz, output int lat);
    @(negedge clk);
    iv1 = 1'b1; op1 = op; sat1 = $urandom_range(0, 1); a1 = a; b1 = b; or1 = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    iv1 = 1'b0;
    while (!ov1 && lat < 10) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    r = o1; lz = lz1;
  endtask

  task automatic test_reset;
    int acc;
    logic bad;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ov0 !== 1'b0 || o0 !== 64'd0 || lz0 !== 4'd0 || ir0 !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: out_valid=%b out=%h lane_zero=%h in_ready=%b, required 0/0/0/1", ov0, o0, lz0, ir0);
    end
    rst_n = 1'b1;
    or0 = 1'b0; acc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      iv0 = 1'b1; op0 = 4'd3; sat0 = 1'b0; a0 = 64'h1234_5678_9ABC_DEF0; b0 = 64'h1;
      #1;
      if (ir0) acc++;
    end
    @(negedge clk);
    iv0 = 1'b0;
    checks++;
    if (acc != 2 || ov0 !== 1'b1) begin
      errors++;
      $display("FAIL capacity: accepted=%0d out_valid=%b, required 2 and 1", acc, ov0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (ov0 !== 1'b0 || o0 !== 64'd0 || lz0 !== 4'd0) begin
      errors++;
      $display("FAIL reset_midstream: out_valid=%b out=%h lane_zero=%h, required 0/0/0", ov0, o0, lz0);
    end
    @(negedge clk);
    rst_n = 1'b1; or0 = 1'b1;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (ov0 !== 1'b0 || ir0 !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_no_stale: stale beat or in_ready low after release (bad=%b), required none", bad);
    end
  endtask

  task automatic check0(input string name, input logic [3:0] op, input logic s,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_r);
    logic [63:0] r;
    logic [3:0]  lz;
    logic [7:0]  ez;
    int lat;
    beat0(op, s, a, b, r, lz, lat);
    ez = mlz(16, 4, exp_r);
    checks++;
    if (r !== exp_r || lz !== ez[3:0] || lat != 2) begin
      errors++;
      $display("FAIL %s: out=%h lz=%h lat=%0d, required out=%h lz=%h lat=2", name, r, lz, lat, exp_r, ez[3:0]);
    end
  endtask

  task automatic test_saturation;
    check0("add_wrap", 4'd0, 1'b0, 64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 64'h0);
    check0("add_sat", 4'd0, 1'b1, 64'h8000_8000_8000_8000, 64'h8000_8000_8000_8000, 64'hFFFF_FFFF_FFFF_FFFF);
    check0("sub_sat", 4'd1, 1'b1, 64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002, 64'h0);
    check0("sub_wrap", 4'd1, 1'b0, 64'h0001_0005_0001_0001, 64'h0002_0003_0002_0002, 64'hFFFF_0002_FFFF_FFFF);
    check0("xor_sat_ignored", 4'd4, 1'b1, 64'hFFFF_0000_1234_0F0F, 64'h0001_0000_1234_F0F0, 64'hFFFE_0000_0000_FFFF);
  endtask

  task automatic test_shift;
    check0("shl_lanes", 4'd5, 1'b0, 64'h8001_8001_8001_8001, 64'h0010_000F_0004_0001, 64'h8001_8000_0010_0002);
    check0("sra_lanes", 4'd8, 1'b0, 64'h8001_8001_8001_8001, 64'h0010_000F_0004_0001, 64'h8001_FFFF_F800_C000);
    check0("shr_lanes", 4'd6, 1'b0, 64'h8001_8001_8001_8001, 64'hFFF0_000F_0004_0001, 64'h8001_0001_0800_4000);
  endtask

  task automatic test_addw;
    check0("addw_carry", 4'd7, 1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000);
    check0("add_no_carry", 4'd0, 1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0);
    check0("addw_wrap", 4'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'h1);
  endtask

  task automatic test_random_ops;
    logic [3:0]  op;
    logic        s;
    logic [63:0] a, b;
    for (int k = 0; k < 32; k++) begin
      op = 4'(k % 16); s = $urandom_range(0, 1);
      a = {$urandom(), $urandom()}; b = (k % 5 == 0) ? a : {$urandom(), $urandom()};
      check0("random_op", op, s, a, b, model(16, 4, op, s, a, b));
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] qr[$];
    logic [63:0] ho, er;
    logic [7:0]  ez;
    logic [3:0]  hz;
    logic        hold;
    int sent, got, cyc;
    sent = 0; got = 0; cyc = 0; hold = 1'b0; ho = '0; hz = '0;
    while (got < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        checks++;
        if (ov0 !== 1'b1 || o0 !== ho || lz0 !== hz) begin
          errors++;
          $display("FAIL hold_stable: out_valid=%b out=%h lz=%h, required 1 %h %h", ov0, o0, lz0, ho, hz);
        end
      end
      iv0 = (sent < 1000) && ($urandom_range(0, 3) != 0);
      op0 = 4'($urandom_range(0, 15)); sat0 = $urandom_range(0, 1);
      a0 = {$urandom(), $urandom()}; b0 = {$urandom(), $urandom()};
      or0 = ($urandom_range(0, 2) != 0);
      #1;
      if (iv0 && ir0) begin
        qr.push_back(model(16, 4, op0, sat0, a0, b0));
        sent++;
      end
      if (ov0 && or0) begin
        checks++;
        if (qr.size() == 0) begin
          errors++;
          $display("FAIL bp_order: unexpected beat out=%h, required no beat", o0);
        end else begin
          er = qr.pop_front();
          ez = mlz(16, 4, er);
          if (o0 !== er || lz0 !== ez[3:0]) begin
            errors++;
            $display("FAIL bp_order: beat %0d out=%h lz=%h, required %h %h", got, o0, lz0, er, ez[3:0]);
          end
        end
        got++;
      end
      hold = ov0 && !or0; ho = o0; hz = lz0;
    end
    checks++;
    if (got < 1000) begin
      errors++;
      $display("FAIL bp_timeout: got %0d beats, required 1000", got);
    end
    @(negedge clk);
    iv0 = 1'b0; or0 = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_throughput;
    logic [63:0] qr[$];
    logic [63:0] er;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      or0 = 1'b1; iv0 = (k < 20);
      op0 = 4'($urandom_range(0, 12)); sat0 = $urandom_range(0, 1);
      a0 = {$urandom(), $urandom()}; b0 = {$urandom(), $urandom()};
      #1;
      if (k < 20) begin
        checks++;
        if (ir0 !== 1'b1) begin
          errors++;
          $display("FAIL tput_ready: cycle %0d in_ready=%b, required 1", k, ir0);
        end
      end
      if (iv0 && ir0) qr.push_back(model(16, 4, op0, sat0, a0, b0));
      if (k >= 2 && k <= 21) begin
        checks++;
        er = (qr.size() != 0) ? qr.pop_front() : 64'hx;
        if (ov0 !== 1'b1 || o0 !== er) begin
          errors++;
          $display("FAIL tput_out: cycle %0d out_valid=%b out=%h, required 1 %h", k, ov0, o0, er);
        end
      end
    end
    @(negedge clk);
    iv0 = 1'b0;
  endtask

  task automatic test_sweep;
    logic [3:0]  ops[5];
    logic [3:0]  op;
    logic [63:0] a, b, r, er;
    logic [7:0]  lz, ez;
    int lat;
    ops = '{4'd9, 4'd10, 4'd11, 4'd12, 4'd14};
    for (int k = 0; k < 40; k++) begin
      op = ops[k % 5];
      a = {$urandom(), $urandom()};
      b = (k % 3 == 0) ? a : {$urandom(), $urandom()};
      if (k % 7 == 0) b[15:8] = a[15:8];
      beat1(op, a, b, r, lz, lat);
      er = model(8, 8, op, 1'b0, a, b);
      ez = mlz(8, 8, er);
      checks++;
      if (r !== er || lz !== ez || lat != 2) begin
        errors++;
        $display("FAIL sweep_op%0d: out=%h lz=%h lat=%0d, required %h %h lat=2", op, r, lz, lat, er, ez);
      end
    end
  endtask

  initial begin
    iv0 = 0; op0 = 0; sat0 = 0; a0 = 0; b0 = 0; or0 = 1;
    iv1 = 0; op1 = 0; sat1 = 0; a1 = 0; b1 = 0; or1 = 1;
    test_reset();
    test_saturation();
    test_shift();
    test_addw();
    test_random_ops();
    test_backpressure();
    test_throughput();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
